// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types for the LSU-to-AHB master bridge: transfer, response and size
// encodings, the bridge state set and the request legality check.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR
    } bridge_state_t;

    // A request may reach the bus only if it hits the slave window, has a legal size
    // and is naturally aligned for that size.
    function automatic logic req_legal(input logic [31:0] addr,
                                       input logic [1:0]  size,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        logic aligned;
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        return ((addr & mask) == base) && aligned;
    endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: replicates store data across HWDATA lanes and extracts the
// addressed lane of HRDATA, zero-extended to 32 bits.
module ahb_lane_align
    import ahb_pkg::*;
(
    input  hsize_t      size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] hrdata_i,
    output logic [31:0] hwdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] lane;

    always_comb begin
        lane     = hrdata_i >> {addr_lo_i, 3'b000};
        hwdata_o = wdata_i;
        rdata_o  = hrdata_i;
        case (size_i)
            HSIZE_BYTE: begin
                hwdata_o = {4{wdata_i[7:0]}};
                rdata_o  = {24'h0, lane[7:0]};
            end
            HSIZE_HALF: begin
                hwdata_o = {2{wdata_i[15:0]}};
                rdata_o  = {16'h0, lane[15:0]};
            end
            default: begin
                hwdata_o = wdata_i;
                rdata_o  = hrdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ahb_lite_master_bridge.sv
// Turns single LSU load/store requests into AHB-Lite SINGLE transfers, one in flight,
// with window/alignment checks, wait states, ERROR responses and a data-phase timeout.
module ahb_lite_master_bridge
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h7000_0000,
    parameter logic [31:0] ADDR_MASK      = 32'hFFFF_F000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        HSEL_o,
    output logic [31:0] HADDR_o,
    output logic [1:0]  HTRANS_o,
    output logic        HWRITE_o,
    output logic [2:0]  HSIZE_o,
    output logic [2:0]  HBURST_o,
    output logic [31:0] HWDATA_o,
    input  logic [31:0] HRDATA_i,
    input  logic        HREADY_i,
    input  logic [1:0]  HRESP_i
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    bridge_state_t    state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             hsel_q, hsel_d;
    logic [31:0]      haddr_q, haddr_d;
    htrans_t          htrans_q, htrans_d;
    logic             hwrite_q, hwrite_d;
    hsize_t           hsize_q, hsize_d;
    logic [31:0]      hwdata_q, hwdata_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             done;
    logic             done_err;
    logic [31:0]      hwdata_rep;
    logic [31:0]      rdata_lane;

    ahb_lane_align u_lane_align (
        .size_i    (hsize_q),
        .addr_lo_i (haddr_q[1:0]),
        .wdata_i   (wdata_q),
        .hrdata_i  (HRDATA_i),
        .hwdata_o  (hwdata_rep),
        .rdata_o   (rdata_lane)
    );

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        hsel_d      = hsel_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        done_err    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    if (req_legal(req_addr_i, req_size_i, BASE_ADDR, ADDR_MASK)) begin
                        state_d     = ST_ADDR;
                        req_ready_d = 1'b0;
                        hsel_d      = 1'b1;
                        htrans_d    = HTRANS_NONSEQ;
                        haddr_d     = req_addr_i;
                        hwrite_d    = req_write_i;
                        hsize_d     = hsize_t'({1'b0, req_size_i});
                        wdata_d     = req_wdata_i;
                        cnt_d       = '0;
                    end else begin
                        // Rejected locally: the bus never sees this request.
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY_i) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwdata_rep;
                    cnt_d    = '0;
                end
            end
            ST_DATA: begin
                if (HREADY_i) begin
                    // A one-cycle ERROR with HREADY high is still reported as an error.
                    done     = 1'b1;
                    done_err = (HRESP_i == HRESP_ERROR);
                end else if (HRESP_i == HRESP_ERROR) begin
                    state_d = ST_ERR;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ERR: begin
                if (HREADY_i) begin
                    done     = 1'b1;
                    done_err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (done) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            hsel_d      = 1'b0;
            htrans_d    = HTRANS_IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = done_err;
            rsp_rdata_d = (done_err || hwrite_q) ? 32'h0 : rdata_lane;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= HSIZE_BYTE;
            hwdata_q    <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            hsel_q      <= hsel_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign HSEL_o      = hsel_q;
    assign HADDR_o     = haddr_q;
    assign HTRANS_o    = htrans_q;
    assign HWRITE_o    = hwrite_q;
    assign HSIZE_o     = hsize_q;
    assign HBURST_o    = HBURST_SINGLE;
    assign HWDATA_o    = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Scoreboard bench for the AHB-Lite master bridge: a driver issues requests and queues
// expected responses, a slave model plays wait/error/timeout scenarios, a monitor checks.
module tb_ahb_lite_master_bridge;

    localparam int K_OK   = 0;
    localparam int K_ERR2 = 1;
    localparam int K_ERR1 = 2;
    localparam int K_TMO  = 3;
    localparam int TMO    = 16;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] hwdata;
        int          aw;
        int          dw;
        int          kind;
        logic [31:0] rdata;
    } plan_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_write_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [1:0]  req_size_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        req_ready_o, rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic        HSEL_o, HWRITE_o;
    logic [31:0] HADDR_o, HWDATA_o;
    logic [1:0]  HTRANS_o;
    logic [2:0]  HSIZE_o, HBURST_o;
    logic [31:0] HRDATA_i = '0;
    logic [1:0]  HRESP_i = '0;
    logic        slave_ready = 1'b1;
    logic        force_wait = 1'b0;
    logic        slave_off = 1'b0;
    wire         HREADY_i = slave_ready & ~force_wait;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [64:0] exp_q[$];
    plan_t       plan_q[$];
    logic [64:0] mon_e;

    ahb_lite_master_bridge dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_size_i  (req_size_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .HSEL_o      (HSEL_o),
        .HADDR_o     (HADDR_o),
        .HTRANS_o    (HTRANS_o),
        .HWRITE_o    (HWRITE_o),
        .HSIZE_o     (HSIZE_o),
        .HBURST_o    (HBURST_o),
        .HWDATA_o    (HWDATA_o),
        .HRDATA_i    (HRDATA_i),
        .HREADY_i    (HREADY_i),
        .HRESP_i     (HRESP_i)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, written from the bridge's rules
    function automatic bit legal(input logic [31:0] addr, input logic [1:0] sz);
        int bytes;
        if (sz == 2'd3) return 0;
        bytes = 1 << sz;
        return ((addr >= 32'h7000_0000) && (addr <= 32'h7000_0FFF) && ((addr % bytes) == 0));
    endfunction

    function automatic logic [31:0] lane_rd(input logic [31:0] rd, input logic [31:0] addr,
                                            input logic [1:0] sz);
        logic [31:0] v;
        v = rd >> (8 * addr[1:0]);
        if (sz == 2'd0) return v % 256;
        if (sz == 2'd1) return v % 65536;
        return rd;
    endfunction

    function automatic logic [31:0] rep_wd(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return (wd % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready_o, 1);
        chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
        chk({tag, "_rsp_err"}, rsp_err_o, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
        chk({tag, "_hsel"}, HSEL_o, 0);
        chk({tag, "_htrans"}, HTRANS_o, 0);
        chk({tag, "_haddr"}, HADDR_o, 0);
        chk({tag, "_hwdata"}, HWDATA_o, 0);
        chk({tag, "_hwrite"}, HWRITE_o, 0);
        chk({tag, "_hsize"}, HSIZE_o, 0);
    endtask

    // Driver: present a request, wait for acceptance, queue expected results
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [31:0] wd, input int aw, input int dw, input int kind,
                         input logic [31:0] rd);
        int n;
        int waited;
        int ex_cyc;
        logic ex_err;
        logic [31:0] ex_rd;
        plan_t p;
        @(negedge clk);
        req_write_i = wr;
        req_addr_i  = addr;
        req_size_i  = sz;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        waited = 0;
        while (!req_ready_o && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("req_accept", req_ready_o, 1);
        if (!req_ready_o) begin
            req_valid_i = 1'b0;
            return;
        end
        n = cyc;
        ex_err = 1'b1;
        ex_rd  = 32'h0;
        ex_cyc = n + 1;
        if (legal(addr, sz)) begin
            case (kind)
                K_OK: begin
                    ex_err = 1'b0;
                    ex_rd  = wr ? 32'h0 : lane_rd(rd, addr, sz);
                    ex_cyc = n + 3 + aw + dw;
                end
                K_ERR2:  ex_cyc = n + 4 + aw + dw;
                K_ERR1:  ex_cyc = n + 3 + aw + dw;
                default: ex_cyc = n + 2 + aw + TMO;
            endcase
            p.write = wr; p.addr = addr; p.size = sz; p.hwdata = rep_wd(wd, sz);
            p.aw = aw; p.dw = dw; p.kind = kind; p.rdata = rd;
            plan_q.push_back(p);
        end
        exp_q.push_back({ex_err, ex_rd, 32'(ex_cyc)});
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
    endtask

    // Monitor: every response pulse is matched against the expected queue
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_err", rsp_err_o, mon_e[64]);
                chk("rsp_rdata", rsp_rdata_o, mon_e[63:32]);
                chk("rsp_cycle", cyc, mon_e[31:0]);
            end
        end
    end

    // Slave model: follows the plan queued for each legal request
    initial begin : slave
        plan_t p;
        forever begin
            @(negedge clk);
            if (!slave_off && HTRANS_o == 2'b10) begin
                if (plan_q.size() == 0) begin
                    chk("unexpected_nonseq", 1, 0);
                end else begin
                    p = plan_q.pop_front();
                    chk("haddr", HADDR_o, p.addr);
                    chk("hwrite", HWRITE_o, p.write);
                    chk("hsize", HSIZE_o, {1'b0, p.size});
                    chk("hsel_addr", HSEL_o, 1);
                    chk("hburst", HBURST_o, 0);
                    for (int k = 0; k < p.aw; k++) begin
                        slave_ready = 1'b0;
                        @(negedge clk);
                        chk("htrans_hold", HTRANS_o, 2);
                        chk("haddr_hold", HADDR_o, p.addr);
                    end
                    slave_ready = 1'b1;
                    @(negedge clk);
                    chk("htrans_data", HTRANS_o, 0);
                    chk("hsel_data", HSEL_o, 1);
                    if (p.write) chk("hwdata", HWDATA_o, p.hwdata);
                    if (p.kind == K_TMO) begin
                        for (int k = 0; k < TMO; k++) begin
                            slave_ready = 1'b0;
                            HRDATA_i = $urandom;
                            @(negedge clk);
                        end
                        slave_ready = 1'b1;
                        chk("hsel_after_timeout", HSEL_o, 0);
                        chk("ready_after_timeout", req_ready_o, 1);
                    end else begin
                        for (int k = 0; k < p.dw; k++) begin
                            slave_ready = 1'b0;
                            HRESP_i = 2'b00;
                            HRDATA_i = $urandom;
                            @(negedge clk);
                        end
                        if (p.kind == K_ERR2) begin
                            slave_ready = 1'b0;
                            HRESP_i = 2'b01;
                            @(negedge clk);
                            slave_ready = 1'b1;
                            @(negedge clk);
                            HRESP_i = 2'b00;
                        end else if (p.kind == K_ERR1) begin
                            slave_ready = 1'b1;
                            HRESP_i = 2'b01;
                            @(negedge clk);
                            HRESP_i = 2'b00;
                        end else begin
                            slave_ready = 1'b1;
                            HRDATA_i = p.rdata;
                            @(negedge clk);
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        int          r;
        int          k;

        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Directed scenarios
        issue(1'b1, 32'h7000_0004, 2'd2, 32'hDEAD_BEEF, 0, 0, K_OK, 32'h0);
        issue(1'b0, 32'h7000_0003, 2'd0, 32'h0, 0, 2, K_OK, 32'hAB00_0000);
        issue(1'b1, 32'h7000_0001, 2'd1, 32'h1234_5678, 0, 0, K_OK, 32'h0);
        issue(1'b0, 32'h8000_0000, 2'd2, 32'h0, 0, 0, K_OK, 32'h0);
        issue(1'b0, 32'h7000_0008, 2'd2, 32'h0, 0, 0, K_ERR2, 32'h0);
        issue(1'b0, 32'h7000_000C, 2'd2, 32'h0, 0, 0, K_TMO, 32'h0);
        issue(1'b0, 32'h7000_0102, 2'd1, 32'h0, 1, 1, K_OK, 32'hCAFE_F00D);
        issue(1'b1, 32'h7000_0203, 2'd0, 32'h0000_005A, 0, 0, K_ERR1, 32'h0);
        issue(1'b0, 32'h7000_0000, 2'd3, 32'h0, 0, 0, K_OK, 32'h0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 70; i++) begin
            wr = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            if (r < 7)       addr = 32'h7000_0000 | 32'($urandom_range(0, 4095));
            else if (r == 7) addr = 32'h7000_1000 | 32'($urandom_range(0, 4095));
            else             addr = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) addr[1:0] = 2'b00;
                if (sz == 2'd1) addr[0] = 1'b0;
            end
            k = $urandom_range(0, 11);
            issue(wr, addr, sz, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                  (k < 8) ? K_OK : (k < 10) ? K_ERR2 : (k == 10) ? K_ERR1 : K_TMO, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        drain();

        // Reset while the address phase is stalled
        slave_off = 1'b1;
        @(negedge clk);
        force_wait  = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h7000_0010;
        req_size_i  = 2'd2;
        req_wdata_i = 32'h5555_AAAA;
        req_valid_i = 1'b1;
        chk("rst_test_ready", req_ready_o, 1);
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_test_nonseq", HTRANS_o, 2);
        chk("rst_test_haddr", HADDR_o, 32'h7000_0010);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("midreset");
        force_wait = 1'b0;
        repeat (6) @(negedge clk);
        slave_off = 1'b0;
        issue(1'b0, 32'h7000_0020, 2'd2, 32'h0, 0, 0, K_OK, 32'h0BAD_F00D);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
